// File: rtl/hood_pkg.sv
// Shared encodings for the range-hood mode scheduler: operating modes,
// fan-speed constants, the request ranking used for arbitration, and the default countdown width.
package hood_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_STBY      = 3'd1,
    MODE_LVL1      = 3'd2,
    MODE_LVL2      = 3'd3,
    MODE_LVL3      = 3'd4,
    MODE_EXIT_WAIT = 3'd5,
    MODE_CLEAN     = 3'd6
  } mode_e;

  // Only the single highest-ranked pending request is ever considered.
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_LVL1,
    REQ_LVL2,
    REQ_LVL3,
    REQ_CLEAN,
    REQ_EXIT
  } req_e;

  localparam logic [1:0] FAN_OFF  = 2'd0;
  localparam logic [1:0] FAN_LOW  = 2'd1;
  localparam logic [1:0] FAN_MED  = 2'd2;
  localparam logic [1:0] FAN_HIGH = 2'd3;

  function automatic logic [1:0] fan_of(input mode_e m);
    case (m)
      MODE_LVL1:      return FAN_LOW;
      MODE_LVL2:      return FAN_MED;
      MODE_LVL3:      return FAN_HIGH;
      MODE_EXIT_WAIT: return FAN_MED;
      default:        return FAN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/hood_mode_ctrl_if.sv
// Menu/display-side bundle of the hood mode scheduler: request strobes
// and power level in, registered mode/fan/countdown status out.
interface hood_mode_ctrl_if #(parameter int CNT_W = hood_pkg::CNT_W_DEF);
  logic             tick_1s;
  logic             power_on;
  logic             req_lvl1;
  logic             req_lvl2;
  logic             req_lvl3;
  logic             req_clean;
  logic             req_exit;
  logic [2:0]       mode;
  logic [1:0]       fan_level;
  logic             cleaning;
  logic [CNT_W-1:0] countdown;
  logic             done;
  logic             lvl3_used;
  logic             clean_reminder;

  modport master (
    output tick_1s, power_on, req_lvl1, req_lvl2, req_lvl3, req_clean, req_exit,
    input  mode, fan_level, cleaning, countdown, done, lvl3_used, clean_reminder
  );

  modport slave (
    input  tick_1s, power_on, req_lvl1, req_lvl2, req_lvl3, req_clean, req_exit,
    output mode, fan_level, cleaning, countdown, done, lvl3_used, clean_reminder
  );
endinterface

// File: rtl/hood_sec_timer.sv
// Loadable seconds down-counter; holds at zero, and expire flags the tick
// that consumes the last remaining second.
module hood_sec_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  input  logic             tick,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= val;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == CNT_W'(1));

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode scheduler: arbitrates menu requests and sequences the timed
// modes from the one-second tick. Optional clean reminder: define CLEAN_REMINDER_EN.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int CLEAN_SECS     = 180,
  parameter int HURRICANE_SECS = 60,
  parameter int EXIT_SECS      = 60
`ifdef CLEAN_REMINDER_EN
  , parameter int REMIND_SECS  = 36000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  hood_mode_ctrl_if.slave  bus
);

  mode_e            mode, nxt_mode;
  req_e             top_req;
  logic [1:0]       fan_level;
  logic             cleaning, done, lvl3_used;
  logic             accepted, done_nxt, set_used, clr_used;
  logic             tmr_load, tmr_clr, tmr_expire;
  logic [CNT_W-1:0] tmr_val, tmr_count;

  always_comb begin
    if      (bus.req_exit)  top_req = REQ_EXIT;
    else if (bus.req_clean) top_req = REQ_CLEAN;
    else if (bus.req_lvl3)  top_req = REQ_LVL3;
    else if (bus.req_lvl2)  top_req = REQ_LVL2;
    else if (bus.req_lvl1)  top_req = REQ_LVL1;
    else                    top_req = REQ_NONE;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nxt_mode = mode;
    accepted = 1'b0;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;
    tmr_val  = '0;
    set_used = 1'b0;
    clr_used = 1'b0;
    done_nxt = 1'b0;
    if (!bus.power_on) begin
      nxt_mode = MODE_OFF;
      tmr_clr  = 1'b1;
    end else if (mode == MODE_OFF) begin
      nxt_mode = MODE_STBY;
      clr_used = 1'b1;
      tmr_clr  = 1'b1;
    end else begin
      case (mode)
        MODE_STBY, MODE_LVL1, MODE_LVL2: begin
          case (top_req)
            REQ_LVL1: begin nxt_mode = MODE_LVL1; accepted = 1'b1; end
            REQ_LVL2: begin nxt_mode = MODE_LVL2; accepted = 1'b1; end
            REQ_LVL3: if (!lvl3_used) begin
              nxt_mode = MODE_LVL3;
              accepted = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(HURRICANE_SECS);
              set_used = 1'b1;
            end
            REQ_CLEAN: if (mode == MODE_STBY) begin
              nxt_mode = MODE_CLEAN;
              accepted = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(CLEAN_SECS);
            end
            REQ_EXIT: if (mode != MODE_STBY) begin nxt_mode = MODE_STBY; accepted = 1'b1; end
            default: ;
          endcase
        end
        MODE_LVL3: if (top_req == REQ_EXIT) begin
          nxt_mode = MODE_EXIT_WAIT;
          accepted = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(EXIT_SECS);
        end
        MODE_EXIT_WAIT: if (top_req == REQ_LVL1 || top_req == REQ_LVL2) begin
          nxt_mode = (top_req == REQ_LVL1) ? MODE_LVL1 : MODE_LVL2;
          accepted = 1'b1;
          tmr_clr  = 1'b1;
        end
        MODE_CLEAN: if (top_req == REQ_EXIT) begin
          nxt_mode = MODE_STBY;
          accepted = 1'b1;
          tmr_clr  = 1'b1;
        end
        default: ;
      endcase
      // The timer only sees ticks not pre-empted by an accepted request.
      if (tmr_expire) begin
        case (mode)
          MODE_LVL3:      nxt_mode = MODE_LVL2;
          MODE_EXIT_WAIT: nxt_mode = MODE_STBY;
          MODE_CLEAN: begin
            nxt_mode = MODE_STBY;
            done_nxt = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  hood_sec_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .val    (tmr_val),
    .tick   (bus.tick_1s && !accepted),
    .clr    (tmr_clr),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode      <= MODE_OFF;
      fan_level <= FAN_OFF;
      cleaning  <= 1'b0;
      done      <= 1'b0;
      lvl3_used <= 1'b0;
    end else begin
      mode      <= nxt_mode;
      fan_level <= fan_of(nxt_mode);
      cleaning  <= (nxt_mode == MODE_CLEAN);
      done      <= done_nxt;
      if (clr_used)      lvl3_used <= 1'b0;
      else if (set_used) lvl3_used <= 1'b1;
    end
  end

`ifdef CLEAN_REMINDER_EN
  logic [15:0] rem_acc, rem_acc_nxt;
  logic        clean_rem;

  // Fan run-time survives power-off; only a completed clean or reset clears it.
  always_comb begin
    rem_acc_nxt = rem_acc;
    if (done_nxt)
      rem_acc_nxt = '0;
    else if (bus.tick_1s && fan_level != FAN_OFF && rem_acc != 16'hFFFF)
      rem_acc_nxt = rem_acc + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_acc   <= '0;
      clean_rem <= 1'b0;
    end else begin
      rem_acc   <= rem_acc_nxt;
      clean_rem <= (int'(rem_acc_nxt) >= REMIND_SECS);
    end
  end

  assign bus.clean_reminder = clean_rem;
`else
  assign bus.clean_reminder = 1'b0;
`endif

  assign bus.mode      = mode;
  assign bus.fan_level = fan_level;
  assign bus.cleaning  = cleaning;
  assign bus.countdown = tmr_count;
  assign bus.done      = done;
  assign bus.lvl3_used = lvl3_used;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Bench for hood_mode_ctrl: directed scenarios plus randomized stimulus,
// all outputs compared every cycle against a rule-level model of the hood.
module tb_hood_mode_ctrl;

  localparam int CNT_W  = 8;
  localparam int CLEAN  = 180;
  localparam int HURR   = 60;
  localparam int EXIT_S = 60;
`ifdef CLEAN_REMINDER_EN
  localparam int REMIND = 5;
`else
  localparam int REMIND = 36000;
`endif

  localparam int OFF = 0, STBY = 1, L1 = 2, L2 = 3, L3 = 4, EW = 5, CL = 6;
  localparam bit [4:0] R_NONE = 5'd0, R_L1 = 5'd1, R_L2 = 5'd2, R_L3 = 5'd4,
                       R_CL = 5'd8, R_EX = 5'd16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hood_mode_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hood_mode_ctrl #(
    .CNT_W          (CNT_W),
    .CLEAN_SECS     (CLEAN),
    .HURRICANE_SECS (HURR),
    .EXIT_SECS      (EXIT_S)
`ifdef CLEAN_REMINDER_EN
    , .REMIND_SECS  (REMIND)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int m_mode, m_cnt, m_done, m_used, m_acc, m_rem;

  function automatic int fan_of(input int m);
    if (m == L1) return 1;
    if (m == L2 || m == EW) return 2;
    if (m == L3) return 3;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = OFF; m_cnt = 0; m_done = 0; m_used = 0; m_acc = 0; m_rem = 0;
  endtask

  // One clock edge of hood behaviour, straight from the mode rules.
  task automatic model_step(input bit tk, input bit [4:0] rq);
    int  fan_prev;
    bit  took;
    bit  lvl_mode;
    fan_prev = fan_of(m_mode);
    took     = 1'b0;
    lvl_mode = (m_mode == STBY || m_mode == L1 || m_mode == L2);
    m_done   = 0;
    if (!bus.power_on) begin
      m_mode = OFF;
      m_cnt  = 0;
    end else if (m_mode == OFF) begin
      m_mode = STBY;
      m_used = 0;
    end else begin
      if (rq[4]) begin
        if (m_mode == L1 || m_mode == L2 || m_mode == CL) begin m_mode = STBY; m_cnt = 0; took = 1; end
        else if (m_mode == L3) begin m_mode = EW; m_cnt = EXIT_S; took = 1; end
      end else if (rq[3]) begin
        if (m_mode == STBY) begin m_mode = CL; m_cnt = CLEAN; took = 1; end
      end else if (rq[2]) begin
        if (lvl_mode && m_used == 0) begin m_mode = L3; m_cnt = HURR; m_used = 1; took = 1; end
      end else if (rq[1]) begin
        if (lvl_mode || m_mode == EW) begin m_mode = L2; m_cnt = 0; took = 1; end
      end else if (rq[0]) begin
        if (lvl_mode || m_mode == EW) begin m_mode = L1; m_cnt = 0; took = 1; end
      end
      if (!took && tk && m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_mode == L3) m_mode = L2;
          else begin
            if (m_mode == CL) m_done = 1;
            m_mode = STBY;
          end
        end
      end
    end
    if (m_done != 0) m_acc = 0;
    else if (tk && fan_prev != 0 && m_acc < 65535) m_acc++;
`ifdef CLEAN_REMINDER_EN
    m_rem = (m_acc >= REMIND) ? 1 : 0;
`else
    m_rem = 0;
`endif
  endtask

  task automatic compare_all();
    check("mode",           bus.mode,           m_mode);
    check("fan_level",      bus.fan_level,      fan_of(m_mode));
    check("cleaning",       bus.cleaning,       (m_mode == CL) ? 1 : 0);
    check("countdown",      bus.countdown,      m_cnt);
    check("done",           bus.done,           m_done);
    check("lvl3_used",      bus.lvl3_used,      m_used);
    check("clean_reminder", bus.clean_reminder, m_rem);
  endtask

  // Called at a falling edge; drives inputs for the next rising edge.
  task automatic step(input bit tk, input bit [4:0] rq);
    bus.tick_1s   = tk;
    bus.req_lvl1  = rq[0];
    bus.req_lvl2  = rq[1];
    bus.req_lvl3  = rq[2];
    bus.req_clean = rq[3];
    bus.req_exit  = rq[4];
    @(posedge clk);
    model_step(tk, rq);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, R_NONE);
      step(1'b0, R_NONE);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_mode", bus.mode, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit [4:0] rq;
    bit       tk;
    int       rate;
    bus.tick_1s = 0; bus.power_on = 0; bus.req_lvl1 = 0; bus.req_lvl2 = 0;
    bus.req_lvl3 = 0; bus.req_clean = 0; bus.req_exit = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    check("reset_mode", bus.mode, 0);
    check("reset_cnt",  bus.countdown, 0);
    rst = 1'b1;

    // Full self-clean.
    bus.power_on = 1'b1;
    step(0, R_NONE);           check("pwr_stby", bus.mode, STBY);
    step(0, R_CL);             check("clean_mode", bus.mode, CL);
    check("clean_cnt", bus.countdown, 180); check("clean_flag", bus.cleaning, 1);
    step(1, R_NONE);           check("clean_first_tick", bus.countdown, 179);
    step(0, R_NONE);
    ticks(178);                check("clean_last_sec", bus.countdown, 1);
    step(1, R_NONE);           check("clean_done", bus.done, 1);
    check("clean_end_mode", bus.mode, STBY); check("clean_end_cnt", bus.countdown, 0);
    step(0, R_NONE);           check("done_pulse", bus.done, 0);

    // Hurricane level and its once-per-power-cycle lockout.
    step(0, R_L3);             check("l3_fan", bus.fan_level, 3);
    check("l3_cnt", bus.countdown, 60); check("l3_used", bus.lvl3_used, 1);
    ticks(59);                 check("l3_still", bus.mode, L3);
    step(1, R_NONE);           check("l3_drop", bus.mode, L2); check("l3_drop_fan", bus.fan_level, 2);
    step(0, R_L3);             check("l3_locked", bus.mode, L2);
    bus.power_on = 1'b0; step(0, R_NONE); check("pwr_off", bus.mode, OFF);
    bus.power_on = 1'b1; step(0, R_NONE); check("used_clr", bus.lvl3_used, 0);

    // Exit from hurricane into run-on, then level override and natural run-on end.
    step(0, R_L3);             check("l3_again", bus.mode, L3);
    ticks(20);                 check("l3_at40", bus.countdown, 40);
    step(0, R_EX);             check("ew_mode", bus.mode, EW);
    check("ew_cnt", bus.countdown, 60); check("ew_fan", bus.fan_level, 2);
    step(0, R_L1);             check("ew_to_l1", bus.mode, L1);
    step(0, R_EX);
    bus.power_on = 1'b0; step(0, R_NONE);
    bus.power_on = 1'b1; step(0, R_NONE);
    step(0, R_L3); step(0, R_EX);
    ticks(60);                 check("ew_expire", bus.mode, STBY);

    // Dropped requests and request-beats-tick.
    step(0, R_L1); step(0, R_CL); check("l1_clean_ign", bus.mode, L1);
    step(0, R_EX);
    step(0, R_EX | R_CL);      check("exit_clean_stby", bus.mode, STBY);
    step(0, R_CL);
    ticks(175);                check("clean_at5", bus.countdown, 5);
    step(1, R_L1);             check("ign_req_tick", bus.countdown, 4);
    step(1, R_EX);             check("req_beats_tick", bus.mode, STBY);
    check("abort_no_done", bus.done, 0);

    // Power loss mid-clean, then async reset mid-hurricane.
    step(0, R_CL);
    ticks(80);                 check("clean_at100", bus.countdown, 100);
    bus.power_on = 1'b0;
    step(0, R_NONE);           check("off_cnt", bus.countdown, 0); check("off_done", bus.done, 0);
    bus.power_on = 1'b1;
    step(0, R_NONE); step(0, R_L3); ticks(3);
    do_reset();

    // Clean reminder.
    step(0, R_NONE); step(0, R_L1);
    ticks(5);
`ifdef CLEAN_REMINDER_EN
    check("remind_set", bus.clean_reminder, 1);
`else
    check("remind_tied", bus.clean_reminder, 0);
`endif
    step(0, R_EX); step(0, R_CL); step(0, R_EX);
`ifdef CLEAN_REMINDER_EN
    check("remind_abort_keep", bus.clean_reminder, 1);
`endif
    step(0, R_CL); ticks(179); step(1, R_NONE);
    check("remind_done", bus.done, 1);
    check("remind_cleared", bus.clean_reminder, 0);

    // Randomized traffic: busy and quiet phases so timed modes also run to completion.
    for (int i = 0; i < 8000; i++) begin
      rate = ((i / 1000) % 2 == 1) ? 400 : 20;
      bus.power_on = ($urandom_range(0, rate * 10 - 1) != 0);
      if ($urandom_range(0, 1999) == 0) do_reset();
      for (int k = 0; k < 5; k++) rq[k] = ($urandom_range(0, rate - 1) == 0);
      tk = ($urandom_range(0, 1) == 0);
      step(tk, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
